// File: rtl/sadd_deser.sv
// sadd_deser -- bit-serial result collector for the serial adder datapath.
//
// Samples the LSB-first sum stream one bit per valid cycle, rebuilds a
// WIDTH-bit word, captures the adder's final carry with the last bit and
// presents word + carry with a one-cycle done pulse.
//
// Optional feature: define SADD_DESER_PARITY_EN to compute registered even
// parity of the captured word; otherwise par is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_b     in   asynchronous active-low reset
//   start     in   begin a new word (clears shift register and bit counter)
//   sum_in    in   serial sum bit, LSB first
//   sum_vld   in   sum_in valid this cycle
//   c_in      in   adder carry, sampled with the last valid bit
//   data_out  out  assembled sum word (registered)
//   cout      out  carry captured with the last bit (registered)
//   par       out  even parity of data_out (0 when parity is not built)
//   busy      out  high while shifting
//   done      out  one-cycle pulse: data_out/cout/par newly updated
module sadd_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             sum_in,
    input  logic             sum_vld,
    input  logic             c_in,
    output logic [WIDTH-1:0] data_out,
    output logic             cout,
    output logic             par,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // The bit that would sit in sr[0] is only ever shifted out, never read,
    // so only the upper WIDTH-1 positions are stored.
    logic [WIDTH-1:1] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word_nxt;
    logic             shift_en;
    logic             last_bit;

    assign word_nxt = {sum_in, sr};

    // start outranks a simultaneous sum_vld, so that bit is dropped.
    assign shift_en = (state == SHIFT) && !start && sum_vld;
    assign last_bit = shift_en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? SHIFT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sr       <= '0;
            cnt      <= '0;
            data_out <= '0;
            cout     <= 1'b0;
        end else begin
            if (start) begin
                sr  <= '0;
                cnt <= '0;
            end else if (shift_en) begin
                sr <= word_nxt[WIDTH-1:1];
                if (last_bit) begin
                    cnt      <= '0;
                    data_out <= word_nxt;
                    cout     <= c_in;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SADD_DESER_PARITY_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            par <= 1'b0;
        end else if (last_bit) begin
            par <= ^word_nxt;
        end
    end
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_sadd_deser.sv
// Directed self-checking bench for sadd_deser (WIDTH = 8).
module tb_sadd_deser;

    localparam int W = 8;

`ifdef SADD_DESER_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_b;
    logic         start;
    logic         sum_in;
    logic         sum_vld;
    logic         c_in;
    logic [W-1:0] data_out;
    logic         cout;
    logic         par;
    logic         busy;
    logic         done;

    int compared   = 0;
    int mismatched = 0;
    int done_pulses = 0;
    int cyc = 0;

    sadd_deser #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .sum_in   (sum_in),
        .sum_vld  (sum_vld),
        .c_in     (c_in),
        .data_out (data_out),
        .cout     (cout),
        .par      (par),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_pulses++;

    // Advance one clock edge; inputs set before the call are sampled at it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Feed one word LSB first; c_in is the inverse of c except on the last bit.
    task automatic feed(input logic [W-1:0] w, input logic c, input bit gapped);
        for (int i = 0; i < W; i++) begin
            sum_in  = w[i];
            sum_vld = 1'b1;
            c_in    = (i == W - 1) ? c : ~c;
            tick();
            if (gapped && i < W - 1) begin
                sum_vld = 1'b0;
                sum_in  = ~w[i];
                c_in    = ~c;
                tick();
            end
        end
        sum_vld = 1'b0;
        sum_in  = 1'b0;
        c_in    = 1'b0;
    endtask

    task automatic test_reset;
        rst_b = 1'b0; start = 1'b0; sum_in = 1'b0; sum_vld = 1'b0; c_in = 1'b0;
        tick(); tick();
        compared++; if (data_out !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", data_out); end
        compared++; if (cout !== 1'b0) begin mismatched++; $display("FAIL reset_cout got %b want 0", cout); end
        compared++; if (par !== 1'b0) begin mismatched++; $display("FAIL reset_par got %b want 0", par); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
        #2 rst_b = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int d0, t0, nbusy;
        d0 = done_pulses;
        nbusy = 0;
        start = 1'b1; tick(); start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1) nbusy++;
            sum_in = (i == 0 || i == 2 || i == 5 || i == 7); // 0xA5 LSB first
            sum_vld = 1'b1;
            c_in = (i == W - 1);
            tick();
        end
        sum_vld = 1'b0; c_in = 1'b0;
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL basic_done got %b want 1", done); end
        compared++; if (cyc - t0 !== W) begin mismatched++; $display("FAIL basic_latency got %0d want %0d", cyc - t0 + 1, W + 1); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_drop got %b want 0", busy); end
        compared++; if (nbusy !== W) begin mismatched++; $display("FAIL basic_busy_cycles got %0d want %0d", nbusy, W); end
        compared++; if (data_out !== 8'hA5) begin mismatched++; $display("FAIL basic_data got %h want a5", data_out); end
        compared++; if (cout !== 1'b1) begin mismatched++; $display("FAIL basic_cout got %b want 1", cout); end
        compared++; if (par !== 1'b0) begin mismatched++; $display("FAIL basic_par got %b want 0", par); end
        tick();
        compared++; if (done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle got done=%b busy=%b want 0 0", done, busy); end
        compared++; if (done_pulses - d0 !== 1) begin mismatched++; $display("FAIL basic_pulses got %0d want 1", done_pulses - d0); end
    endtask

    task automatic test_gapped;
        int d0;
        d0 = done_pulses;
        sum_vld = 1'b1; sum_in = 1'b1;
        tick(); tick(); tick();
        sum_vld = 1'b0; sum_in = 1'b0;
        compared++; if (busy !== 1'b0 || done_pulses !== d0) begin mismatched++; $display("FAIL idle_vld_ignored got busy=%b pulses=%0d want 0 0", busy, done_pulses - d0); end
        compared++; if (data_out !== 8'hA5) begin mismatched++; $display("FAIL idle_data_hold got %h want a5", data_out); end
        start = 1'b1; tick(); start = 1'b0;
        feed(8'h3C, 1'b0, 1'b1);
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL gap_done got %b want 1", done); end
        compared++; if (done_pulses - d0 !== 0) begin mismatched++; $display("FAIL gap_early_done got %0d want 0", done_pulses - d0); end
        compared++; if (data_out !== 8'h3C) begin mismatched++; $display("FAIL gap_data got %h want 3c", data_out); end
        compared++; if (cout !== 1'b0) begin mismatched++; $display("FAIL gap_cout got %b want 0", cout); end
        compared++; if (par !== 1'b0) begin mismatched++; $display("FAIL gap_par got %b want 0", par); end
        tick();
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_pulses;
        start = 1'b1; tick(); start = 1'b0;
        sum_vld = 1'b1; sum_in = 1'b1;
        tick(); tick(); tick(); tick();
        // start together with a valid bit: the bit must be discarded
        start = 1'b1;
        tick();
        start = 1'b0; sum_vld = 1'b0; sum_in = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_busy got %b want 1", busy); end
        compared++; if (data_out !== 8'h3C) begin mismatched++; $display("FAIL abort_data_hold got %h want 3c", data_out); end
        feed(8'h01, 1'b0, 1'b0);
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL abort_done got %b want 1", done); end
        compared++; if (done_pulses - d0 !== 0) begin mismatched++; $display("FAIL abort_no_done got %0d want 0", done_pulses - d0); end
        compared++; if (data_out !== 8'h01) begin mismatched++; $display("FAIL abort_data got %h want 01", data_out); end
        compared++; if (cout !== 1'b0) begin mismatched++; $display("FAIL abort_cout got %b want 0", cout); end
        compared++; if (par !== PAR_EN) begin mismatched++; $display("FAIL abort_par got %b want %b", par, PAR_EN); end
        tick();
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        start = 1'b1; tick(); start = 1'b0;
        feed(8'h5A, 1'b0, 1'b0);
        t1 = cyc;
        compared++; if (done !== 1'b1 || data_out !== 8'h5A) begin mismatched++; $display("FAIL b2b_first got done=%b data=%h want 1 5a", done, data_out); end
        start = 1'b1; tick(); start = 1'b0;
        compared++; if (busy !== 1'b1 || done !== 1'b0) begin mismatched++; $display("FAIL b2b_no_bubble got busy=%b done=%b want 1 0", busy, done); end
        feed(8'h81, 1'b1, 1'b0);
        t2 = cyc;
        compared++; if (done !== 1'b1 || data_out !== 8'h81) begin mismatched++; $display("FAIL b2b_second got done=%b data=%h want 1 81", done, data_out); end
        compared++; if (t2 - t1 !== W + 1) begin mismatched++; $display("FAIL b2b_period got %0d want %0d", t2 - t1, W + 1); end
        compared++; if (cout !== 1'b1 || par !== 1'b0) begin mismatched++; $display("FAIL b2b_cout_par got %b %b want 1 0", cout, par); end
        tick();
    endtask

    task automatic test_reset_mid;
        start = 1'b1; tick(); start = 1'b0;
        sum_vld = 1'b1; sum_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        sum_vld = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        compared++; if (data_out !== 8'h00 || cout !== 1'b0 || par !== 1'b0) begin mismatched++; $display("FAIL rstmid_outputs got data=%h cout=%b par=%b want 00 0 0", data_out, cout, par); end
        compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("FAIL rstmid_idle got busy=%b done=%b want 0 0", busy, done); end
        #1 rst_b = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        feed(8'h0F, 1'b1, 1'b0);
        compared++; if (done !== 1'b1 || data_out !== 8'h0F) begin mismatched++; $display("FAIL rstmid_word got done=%b data=%h want 1 0f", done, data_out); end
        compared++; if (cout !== 1'b1 || par !== 1'b0) begin mismatched++; $display("FAIL rstmid_cout_par got %b %b want 1 0", cout, par); end
        tick();
    endtask

    task automatic test_parity;
        start = 1'b1; tick(); start = 1'b0;
        feed(8'h07, 1'b0, 1'b0);
        compared++; if (done !== 1'b1 || data_out !== 8'h07) begin mismatched++; $display("FAIL parity_word got done=%b data=%h want 1 07", done, data_out); end
        compared++; if (par !== PAR_EN) begin mismatched++; $display("FAIL parity_bit got %b want %b", par, PAR_EN); end
        tick();
        compared++; if (done !== 1'b0 || par !== PAR_EN) begin mismatched++; $display("FAIL parity_hold got done=%b par=%b want 0 %b", done, par, PAR_EN); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
